// File: rtl/sliding_window_stream_if.sv
// sliding_window_stream_if: raster pixel stream in, K x K window stream out
interface sliding_window_stream_if #(
    parameter int KERNEL_SIZE   = 3,
    parameter int MAX_ROW_WIDTH = 800,
    parameter int WORD_SIZE     = 8,
    parameter int CHANNELS      = 1
);
    localparam int CW = $clog2(MAX_ROW_WIDTH + 1);
    localparam int PW = $clog2(MAX_ROW_WIDTH);
    logic [CW-1:0]                                          row_width;
    logic                                                   in_valid;
    logic                                                   in_sof;
    logic [CHANNELS*WORD_SIZE-1:0]                          pixel_in;
    logic [CHANNELS*KERNEL_SIZE*KERNEL_SIZE*WORD_SIZE-1:0]  window;
    logic                                                   out_valid;
    logic                                                   out_sof;
    logic [PW-1:0]                                          out_row;
    logic [PW-1:0]                                          out_col;
    logic                                                   err_width;
    modport master (
        output row_width, in_valid, in_sof, pixel_in,
        input  window, out_valid, out_sof, out_row, out_col, err_width
    );
    modport slave (
        input  row_width, in_valid, in_sof, pixel_in,
        output window, out_valid, out_sof, out_row, out_col, err_width
    );
endinterface

// File: rtl/sliding_window_stream.sv
// sliding_window_stream: K x K multi-channel window generator with runtime row width and frame tracking
module sliding_window_stream #(
    parameter int KERNEL_SIZE   = 3,
    parameter int MAX_ROW_WIDTH = 800,
    parameter int WORD_SIZE     = 8,
    parameter int CHANNELS      = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    sliding_window_stream_if.slave  bus
);
    localparam int K  = KERNEL_SIZE;
    localparam int WS = WORD_SIZE;
    localparam int CH = CHANNELS;
    localparam int CW = $clog2(MAX_ROW_WIDTH + 1);
    localparam int PW = $clog2(MAX_ROW_WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wid_q, wid_d;
    logic [PW-1:0]     col_q, col_d, row_q, row_d, orow_q, orow_d, ocol_q, ocol_d;
    logic [PW-1:0]     pc, pr;
    logic              ov_q, ov_d, os_q, os_d, err_q, err_d;
    logic              legal, start, act, last;
    logic [WS-1:0]     win_q [CH][K][K];
    logic [WS-1:0]     win_d [CH][K][K];
    logic [CH*WS-1:0]  lb_q  [K-1][MAX_ROW_WIDTH];
    logic [CH*WS-1:0]  col_in [K];

    assign legal = bus.row_width >= CW'(K) && bus.row_width <= CW'(MAX_ROW_WIDTH);
    assign start = bus.in_valid && bus.in_sof;
    assign act   = bus.in_valid && (bus.in_sof ? legal : state_q == RUN);
    // a frame start overrides whatever position the counters hold
    assign pc    = bus.in_sof ? '0 : col_q;
    assign pr    = bus.in_sof ? '0 : row_q;
    assign last  = CW'(pc) == wid_d - CW'(1);

    // column entering the window: older rows from the line buffers, newest row from the input
    assign col_in[K-1] = bus.pixel_in;
    for (genvar r = 0; r < K-1; r++) begin : g_tap
        assign col_in[r] = lb_q[r][pc];
    end

    // next state, frame counters, validity and window shift
    always_comb begin
        state_d = state_q;
        wid_d   = wid_q;
        col_d   = col_q;
        row_d   = row_q;
        orow_d  = orow_q;
        ocol_d  = ocol_q;
        err_d   = err_q;
        win_d   = win_q;
        ov_d    = 1'b0;
        os_d    = 1'b0;
        if (start) begin
            state_d = legal ? RUN : IDLE;
            err_d   = !legal;
            wid_d   = legal ? bus.row_width : wid_q;
        end
        if (act) begin
            col_d  = last ? '0 : pc + PW'(1);
            row_d  = last ? ((&pr) ? pr : pr + PW'(1)) : pr;
            orow_d = pr;
            ocol_d = pc;
            ov_d   = pr >= PW'(K-1) && pc >= PW'(K-1);
            os_d   = pr == PW'(K-1) && pc == PW'(K-1);
            for (int c = 0; c < CH; c++)
                for (int r = 0; r < K; r++) begin
                    for (int k = 0; k < K-1; k++)
                        win_d[c][r][k] = win_q[c][r][k+1];
                    win_d[c][r][K-1] = col_in[r][c*WS +: WS];
                end
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wid_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            orow_q  <= '0;
            ocol_q  <= '0;
            ov_q    <= 1'b0;
            os_q    <= 1'b0;
            err_q   <= 1'b0;
            win_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            wid_q   <= wid_d;
            col_q   <= col_d;
            row_q   <= row_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            ov_q    <= ov_d;
            os_q    <= os_d;
            err_q   <= err_d;
            win_q   <= win_d;
        end
    end

    // line buffer cascade: each buffer takes the sample the buffer above just handed to the window
    always_ff @(posedge clk) begin
        if (act)
            for (int r = 0; r < K-1; r++)
                lb_q[r][pc] <= col_in[r+1];
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        for (genvar r = 0; r < K; r++) begin : g_row
            for (genvar k = 0; k < K; k++) begin : g_col
                assign bus.window[((c*K+r)*K+k)*WS +: WS] = win_q[c][r][k];
            end
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.out_sof   = os_q;
    assign bus.out_row   = orow_q;
    assign bus.out_col   = ocol_q;
    assign bus.err_width = err_q;
endmodule

// File: tb/tb_sliding_window_stream.sv
// tb_sliding_window_stream: directed streams against a frame-store model for K=3 and K=5 instances
module tb_sliding_window_stream;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        v [2];
    logic        s [2];
    logic [15:0] pix [2];
    logic [9:0]  w [2];

    sliding_window_stream_if #(.KERNEL_SIZE(3), .MAX_ROW_WIDTH(800), .WORD_SIZE(8), .CHANNELS(1)) if3 ();
    sliding_window_stream_if #(.KERNEL_SIZE(5), .MAX_ROW_WIDTH(16), .WORD_SIZE(8), .CHANNELS(2)) if5 ();

    assign if3.in_valid  = v[0];
    assign if3.in_sof    = s[0];
    assign if3.pixel_in  = pix[0][7:0];
    assign if3.row_width = w[0];
    assign if5.in_valid  = v[1];
    assign if5.in_sof    = s[1];
    assign if5.pixel_in  = pix[1];
    assign if5.row_width = w[1][4:0];

    sliding_window_stream #(.KERNEL_SIZE(3), .MAX_ROW_WIDTH(800), .WORD_SIZE(8), .CHANNELS(1)) d3 (
        .clk(clk), .reset_n(rst_n), .bus(if3));
    sliding_window_stream #(.KERNEL_SIZE(5), .MAX_ROW_WIDTH(16), .WORD_SIZE(8), .CHANNELS(2)) d5 (
        .clk(clk), .reset_n(rst_n), .bus(if5));

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [399:0] a, input logic [399:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // model: stores the current frame and cuts the window out of it
    int          mk [2] = '{3, 5};
    int          mx [2] = '{800, 16};
    int          nc [2] = '{1, 2};
    logic [15:0] fr [2][32][16];
    bit          run [2], merr [2], known [2], ev [2], es [2];
    int          wid [2], mr [2], mc [2], er [2], ec [2];
    logic [399:0] ew [2];
    bit          lg;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                run[i] = 0; merr[i] = 0; known[i] = 1; ev[i] = 0; es[i] = 0;
                er[i] = 0; ec[i] = 0; ew[i] = '0; wid[i] = 0; mr[i] = 0; mc[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                lg = int'(w[i]) >= mk[i] && int'(w[i]) <= mx[i];
                ev[i] = 0;
                es[i] = 0;
                if (v[i] && s[i]) begin
                    run[i] = lg;
                    merr[i] = !lg;
                    if (lg) begin wid[i] = int'(w[i]); mr[i] = 0; mc[i] = 0; end
                end
                if (v[i] && run[i]) begin
                    if (mr[i] < 32) fr[i][mr[i]][mc[i]] = pix[i];
                    er[i] = mr[i];
                    ec[i] = mc[i];
                    ev[i] = mr[i] >= mk[i]-1 && mc[i] >= mk[i]-1;
                    es[i] = ev[i] && mr[i] == mk[i]-1 && mc[i] == mk[i]-1;
                    known[i] = ev[i];
                    if (ev[i])
                        for (int c = 0; c < nc[i]; c++)
                            for (int r = 0; r < mk[i]; r++)
                                for (int k = 0; k < mk[i]; k++)
                                    ew[i][((c*mk[i]+r)*mk[i]+k)*8 +: 8] =
                                        fr[i][mr[i]-mk[i]+1+r][mc[i]-mk[i]+1+k][c*8 +: 8];
                    mc[i]++;
                    if (mc[i] == wid[i]) begin mc[i] = 0; mr[i]++; end
                end
            end
        end
    end

    int          n_v [2], n_s [2];
    logic [399:0] fw [2], lw [2];
    bit          fs [2];

    // compare DUT outputs against the model on every cycle
    always @(negedge clk) begin
        check("k3_valid", 400'(if3.out_valid), 400'(ev[0]));
        check("k3_sof", 400'(if3.out_sof), 400'(es[0]));
        check("k3_err", 400'(if3.err_width), 400'(merr[0]));
        check("k3_row", 400'(if3.out_row), 400'(er[0]));
        check("k3_col", 400'(if3.out_col), 400'(ec[0]));
        if (known[0]) check("k3_window", 400'(if3.window), 400'(ew[0][71:0]));
        check("k5_valid", 400'(if5.out_valid), 400'(ev[1]));
        check("k5_sof", 400'(if5.out_sof), 400'(es[1]));
        check("k5_err", 400'(if5.err_width), 400'(merr[1]));
        check("k5_row", 400'(if5.out_row), 400'(er[1]));
        check("k5_col", 400'(if5.out_col), 400'(ec[1]));
        if (known[1]) check("k5_window", if5.window, ew[1]);
        if (if3.out_valid) begin
            n_v[0]++;
            if (n_v[0] == 1) begin fw[0] = 400'(if3.window); fs[0] = if3.out_sof; end
            lw[0] = 400'(if3.window);
        end
        if (if5.out_valid) begin
            n_v[1]++;
            if (n_v[1] == 1) begin fw[1] = if5.window; fs[1] = if5.out_sof; end
            lw[1] = if5.window;
        end
        if (if3.out_sof) n_s[0]++;
        if (if5.out_sof) n_s[1]++;
    end

    task automatic beat(input int i, input bit vv, input bit ss, input logic [15:0] p, input int ww);
        @(negedge clk);
        v[i] = vv; s[i] = ss; pix[i] = p; w[i] = 10'(ww);
        v[1-i] = 0; s[1-i] = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            v[0] = 0; v[1] = 0; s[0] = 0; s[1] = 0;
        end
    endtask

    task automatic clear();
        n_v[0] = 0; n_v[1] = 0; n_s[0] = 0; n_s[1] = 0;
        fw[0] = '0; fw[1] = '0; lw[0] = '0; lw[1] = '0; fs[0] = 0; fs[1] = 0;
    endtask

    task automatic stream(input int i, input int n, input int wd, input bit gap, input int sof2);
        for (int p = 1; p <= n; p++) begin
            beat(i, 1, p == 1 || p == sof2, {8'(p + 100), 8'(p)}, wd);
            if (gap) idle(1);
        end
    endtask

    initial begin
        logic [71:0] lit_first, lit_last;
        lit_first = {8'd13, 8'd12, 8'd11, 8'd8, 8'd7, 8'd6, 8'd3, 8'd2, 8'd1};
        lit_last  = {8'd25, 8'd24, 8'd23, 8'd20, 8'd19, 8'd18, 8'd15, 8'd14, 8'd13};
        v = '{0, 0}; s = '{0, 0}; pix = '{0, 0}; w = '{0, 0};
        clear();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_window", 400'(if3.window), 400'(0));
        check("reset_valid", 400'(if3.out_valid), 400'(0));
        check("reset_err", 400'(if5.err_width), 400'(0));
        #2 rst_n = 1'b1;
        idle(2);

        clear();
        stream(0, 25, 5, 0, 0);
        idle(3);
        check("t1_count", 400'(n_v[0]), 400'(9));
        check("t1_sof_count", 400'(n_s[0]), 400'(1));
        check("t1_first_window", fw[0], 400'(lit_first));
        check("t1_first_sof", 400'(fs[0]), 400'(1));
        check("t1_last_window", lw[0], 400'(lit_last));

        clear();
        stream(0, 25, 5, 1, 0);
        idle(3);
        check("t2_count", 400'(n_v[0]), 400'(9));
        check("t2_first_window", fw[0], 400'(lit_first));
        check("t2_last_window", lw[0], 400'(lit_last));

        clear();
        stream(1, 100, 10, 0, 0);
        idle(3);
        check("t3_count", 400'(n_v[1]), 400'(36));
        check("t3_centre_ch0", 400'(fw[1][103:96]), 400'(23));
        check("t3_centre_ch1", 400'(fw[1][303:296]), 400'(123));
        check("t3_sof_count", 400'(n_s[1]), 400'(1));

        clear();
        beat(0, 1, 1, 16'd1, 2);
        idle(2);
        check("t4_err_set", 400'(if3.err_width), 400'(1));
        for (int p = 0; p < 20; p++) beat(0, 1, 0, 16'(p), 2);
        idle(2);
        check("t4_no_valid", 400'(n_v[0]), 400'(0));
        stream(0, 25, 5, 0, 0);
        idle(3);
        check("t4_err_cleared", 400'(if3.err_width), 400'(0));
        check("t4_count", 400'(n_v[0]), 400'(9));
        beat(0, 1, 1, 16'd9, 801);
        idle(2);
        check("t4_err_801", 400'(if3.err_width), 400'(1));
        beat(0, 1, 1, 16'd9, 3);
        idle(2);
        check("t4_err_width3", 400'(if3.err_width), 400'(0));

        clear();
        stream(0, 41, 5, 0, 17);
        idle(3);
        check("t5_count", 400'(n_v[0]), 400'(12));
        check("t5_sof_count", 400'(n_s[0]), 400'(2));

        clear();
        stream(0, 7, 5, 0, 0);
        @(negedge clk);
        v[0] = 0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_window_zero", 400'(if3.window), 400'(0));
        check("t6_row_zero", 400'(if3.out_row), 400'(0));
        check("t6_col_zero", 400'(if3.out_col), 400'(0));
        check("t6_valid_zero", 400'(if3.out_valid), 400'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;
        clear();
        for (int p = 0; p < 20; p++) beat(0, 1, 0, 16'(p + 50), 5);
        idle(3);
        check("t6_no_valid", 400'(n_v[0]), 400'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sliding_window_stream.md
# sliding_window_stream

Streaming K×K window generator with valid-qualified input, runtime row width, multi-channel pixels and frame/border tracking. It is the next generation of the team's fixed-width sliding window. Pixels arrive in raster order, one per accepted cycle, from the camera/pixel pipeline. The block presents a registered K×K window per channel to the convolution stage, with `out_valid` asserted only when every window tap lies inside the current frame.

## Interface
- `KERNEL_SIZE`, default 3: window dimension K; odd, ≥3.
- `MAX_ROW_WIDTH`, default 800: line-buffer depth; maximum runtime row width.
- `WORD_SIZE`, default 8: bits per channel sample, signed.
- `CHANNELS`, default 1: samples per pixel, processed in lockstep.

Ports:
- `clk` in, 1: single clock, rising edge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `row_width` in, $clog2(MAX_ROW_WIDTH+1): pixels per row; sampled only on an accepted `in_sof`.
- `in_valid` in, 1: `pixel_in` is valid this cycle. No backpressure; every valid beat is accepted.
- `in_sof` in, 1: qualified by `in_valid`; the current pixel is frame pixel (0,0).
- `pixel_in` in, CHANNELS*WORD_SIZE: channel c occupies bits [(c+1)*WORD_SIZE-1 : c*WORD_SIZE].
- `window` out, CHANNELS*K*K*WORD_SIZE: tap (c,r,k) at flat index ((c*K+r)*K+k)*WORD_SIZE. r=K-1 is the newest row; k=K-1 is the newest column.
- `out_valid` out, 1: `window` is fully inside the frame.
- `out_sof` out, 1: first `out_valid` window of the frame.
- `out_row`, `out_col` out, $clog2(MAX_ROW_WIDTH) each: frame coordinates of the newest tap (r=K-1, k=K-1).
- `err_width` out, 1: sticky; the last sampled `row_width` was illegal.

## Operation
- **State machine: IDLE → RUN.**
  - IDLE: beats without `in_sof` are ignored (no shift, no buffer write).
  - Accepted `in_sof` with K ≤ `row_width` ≤ MAX_ROW_WIDTH: latch the width, set col=0 and row=0, clear `err_width`, enter RUN.
  - Illegal width: set `err_width`, go to or stay in IDLE.
- **RUN:**
  - Each accepted beat shifts every window row left by one tap. `window[c][K-1][K-1]` ← `pixel_in`.
  - `window[c][r][K-1]` ← line buffer r at address col, for r < K-1.
  - The line buffers form a K-1 deep cascade. Line buffer r-1 at address col is written with the sample leaving row r (the read-before-write value), so each line buffer holds the previous row's samples.
- **Counters:**
  - col increments per accepted beat and wraps to 0 after `row_width`-1. On wrap, row increments and saturates at all-ones.
  - An accepted `in_sof` in RUN restarts the frame: width is re-latched, counters reset. A bad width there goes to IDLE with `err_width` set.
- **Validity:** `out_valid` = beat accepted AND row ≥ K-1 AND col ≥ K-1, using the coordinates of the accepted pixel. Windows at col < K-1 mix data from the previous row's tail; they are never flagged valid.
- **Windows per frame:** with W columns and H rows, exactly (H-K+1)(W-K+1).
- **`out_sof`:** asserted with the first `out_valid` after each frame start (row=K-1, col=K-1).
- Line-buffer contents are not cleared on reset or sof; validity gating alone hides stale data.
- Arithmetic is pass-through; there is no sign extension or truncation of samples.

## Timing
- **Latency:** one cycle. The beat accepted at edge N appears on `window`/`out_valid`/`out_row`/`out_col` after edge N.
- `out_valid` and `out_sof` are single-cycle pulses per qualifying beat and are low on idle cycles. `window` holds its value while `in_valid`=0.
- **Gaps:** `in_valid` gaps of any length do not alter the window sequence, only its timing.
- **Simultaneous events:** `in_sof` on the last pixel of a row or frame wins over the normal wrap.
- **Reset values:**
  - `window`: all 0.
  - `out_valid`, `out_sof`, `err_width`: 0.
  - `out_row`, `out_col`: 0.
  - State: IDLE.
- **Reset mid-frame:** outputs clear immediately (asynchronous). The first beat after release is ignored unless it carries `in_sof`.

## Test plan
- K=3, width=5, single channel, pixels 1..25 with sof on 1, back-to-back: first `out_valid` the cycle after pixel 13, with rows {1,2,3},{6,7,8},{11,12,13} and `out_sof`=1. Exactly 9 valid windows; the last is {13..15},{18..20},{23..25}.
- Same stream with `in_valid` toggling 1,0,1,0: identical 9-window sequence. `window` is stable during gaps; no `out_valid` on gap cycles.
- CHANNELS=2, channel 1 = pixel+100, K=5, width=10, 100 pixels: channel 0 centre tap of the first window = 23 and channel 1 = 123. 36 valid windows.
- `row_width`=2 with sof: `err_width`=1 and the following 20 beats produce no `out_valid`. Then sof with width=5 clears `err_width` and streaming resumes normally.
- Sof reasserted at pixel 17 of a 5-wide frame: counters restart, and the next `out_valid` comes only after 13 further pixels, with `out_sof`=1.
- `reset_n` pulsed low asynchronously mid-row: all outputs 0 with no clock edge. Beats after release without sof produce no `out_valid`.
